// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// the frame-length helper.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP
  } state_t;

  // Clock cycles of TX line activity for one complete frame.
  function automatic int unsigned frame_len(input int unsigned word_length,
                                            input int unsigned clks_per_bit,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return (1 + word_length + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read port as seen between the FIFO (master) and the drain (slave).
interface uart_tx_fifo_drain_if #(
  parameter int WORD_LENGTH = 8
);
  logic [WORD_LENGTH-1:0] i_fifo_data;
  logic                   i_fifo_empty;
  logic                   o_fifo_read_en;

  modport master (
    output i_fifo_data,
    output i_fifo_empty,
    input  o_fifo_read_en
  );

  modport slave (
    input  i_fifo_data,
    input  i_fifo_empty,
    output o_fifo_read_en
  );
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// o_bit_done on the last cycle of each bit period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_done
);
  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last  = (r_count == LAST);
  assign o_bit_done = i_enable & w_at_last;

  // Free-running bit timer, restarted by i_clear and wrapping at each bit boundary.
  // NOTE: reset is sampled on the clock edge (synchronous, active-low), so it sits inside the clocked branch.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_last ? '0 : r_count + CW'(1);
    end
  end
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops words from the FIFO and serialises them as UART frames:
// start bit, LSB-first data, optional even parity, 1 or 2 stop bits.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_en,
  uart_tx_fifo_drain_if.slave  fifo_if,
  output logic                 o_tx,
  output logic                 o_busy
);
  localparam int               BIT_W     = $clog2(WORD_LENGTH + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(WORD_LENGTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  state_t                 r_state;
  logic [WORD_LENGTH-1:0] r_shift;
  logic                   r_parity;
  logic [BIT_W-1:0]       r_bit_idx;
  logic                   r_tx;

  logic w_pop;
  logic w_bit_done;

  // Pop only from IDLE; gating with reset keeps a word from being popped
  // and then discarded while the block is held in reset.
  assign w_pop = i_reset & i_tx_en & ~fifo_if.i_fifo_empty & (r_state == ST_IDLE);

  assign fifo_if.o_fifo_read_en = w_pop;
  assign o_tx                   = r_tx;
  assign o_busy                 = (r_state != ST_IDLE) | w_pop;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_pop),
    .i_enable   (r_state != ST_IDLE),
    .o_bit_done (w_bit_done)
  );

  // Frame sequencer: state, shift register, parity, bit index and registered TX line.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift   <= fifo_if.i_fifo_data;
            r_parity  <= ^fifo_if.i_fifo_data;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            if (r_bit_idx == LAST_DATA) begin
              r_bit_idx <= '0;
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + BIT_W'(1);
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            if (r_bit_idx == LAST_STOP) begin
              r_bit_idx <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain. Two instances share clock and
// reset: A (no parity, 1 stop) and B (even parity, 2 stops), both at 4 clocks
// per bit. Expected TX waveforms come from a bit-list model of the frame.
module tb_uart_tx_fifo_drain;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en_a = 1'b1;
  logic tx_en_b = 1'b1;
  logic tx_a, tx_b, busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic exp_bits[$];

  // Simple FIFO models feeding each DUT; read pointer advances on the pop strobe.
  logic [7:0] mem_a [0:31];
  logic [7:0] mem_b [0:31];
  logic [4:0] wr_a = '0, rd_a = '0, wr_b = '0, rd_b = '0;

  uart_tx_fifo_drain_if #(.WORD_LENGTH(8)) if_a ();
  uart_tx_fifo_drain_if #(.WORD_LENGTH(8)) if_b ();

  assign if_a.i_fifo_data  = mem_a[rd_a];
  assign if_a.i_fifo_empty = (rd_a == wr_a);
  assign if_b.i_fifo_data  = mem_b[rd_b];
  assign if_b.i_fifo_empty = (rd_b == wr_b);

  always @(posedge clk) begin
    if (if_a.o_fifo_read_en) rd_a <= rd_a + 5'd1;
    if (if_b.o_fifo_read_en) rd_b <= rd_b + 5'd1;
  end

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(
    .WORD_LENGTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)
  ) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_tx_en(tx_en_a),
    .fifo_if(if_a.slave), .o_tx(tx_a), .o_busy(busy_a)
  );

  uart_tx_fifo_drain #(
    .WORD_LENGTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)
  ) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_tx_en(tx_en_b),
    .fifo_if(if_b.slave), .o_tx(tx_b), .o_busy(busy_b)
  );

  function automatic logic get_tx(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  function automatic logic get_ren(input int sel);
    return (sel != 0) ? if_b.o_fifo_read_en : if_a.o_fifo_read_en;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] w);
    if (sel != 0) begin
      mem_b[wr_b] = w;
      wr_b = wr_b + 5'd1;
    end else begin
      mem_a[wr_a] = w;
      wr_a = wr_a + 5'd1;
    end
  endtask

  // Reference frame as a list of line levels, one per bit period.
  task automatic build_model(input int sel, input logic [7:0] w);
    int ones;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(w[i]);
      if (w[i]) ones++;
    end
    if (sel != 0) exp_bits.push_back(ones % 2 == 1);
    for (int s = 0; s < ((sel != 0) ? 2 : 1); s++) exp_bits.push_back(1'b1);
  endtask

  task automatic idle_check(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      check($sformatf("idle_tx_%0d_%0d", sel, i), get_tx(sel), 1);
      check($sformatf("idle_busy_%0d_%0d", sel, i), get_busy(sel), 0);
      check($sformatf("idle_ren_%0d_%0d", sel, i), get_ren(sel), 0);
    end
  endtask

  // Waits for the pop, then checks every frame cycle against the model.
  // drop_en_at / reset_at (frame cycle, -1 = never) inject disturbances on A.
  task automatic run_frame(input int sel, input logic [7:0] w, input int exp_wait,
                           input int drop_en_at, input int reset_at);
    int waited;
    int f;
    int b;
    logic [7:0] dec;
    build_model(sel, w);
    f = exp_bits.size() * CPB;
    waited = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (get_ren(sel)) begin
        waited = i;
        break;
      end
    end
    check($sformatf("pop_wait_%0d_%0h", sel, w), waited, exp_wait);
    if (waited < 0) return;
    check($sformatf("busy_pop_%0d_%0h", sel, w), get_busy(sel), 1);
    dec = '0;
    for (int k = 1; k <= f; k++) begin
      @(negedge clk); #1;
      b = (k - 1) / CPB;
      check($sformatf("tx_%0d_%0h_c%0d", sel, w, k), get_tx(sel), exp_bits[b]);
      check($sformatf("busy_%0d_%0h_c%0d", sel, w, k), get_busy(sel), 1);
      check($sformatf("ren_%0d_%0h_c%0d", sel, w, k), get_ren(sel), 0);
      if (b >= 1 && b <= 8 && ((k - 1) % CPB) == CPB / 2) dec[b-1] = get_tx(sel);
      if (k == drop_en_at) tx_en_a = 1'b0;
      if (k == reset_at) begin
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_tx", get_tx(sel), 1);
        check("rst_mid_busy", get_busy(sel), 0);
        check("rst_mid_ren", get_ren(sel), 0);
        rst_n = 1'b1;
        return;
      end
    end
    check($sformatf("decoded_%0d", sel), dec, w);
  endtask

  initial begin
    logic [7:0] rw [4];

    // Reset and idle
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_tx_b", tx_b, 1);
    check("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    idle_check(0, 100);
    idle_check(1, 5);

    // Single frame 0x55
    @(posedge clk); #1;
    push(0, 8'h55);
    run_frame(0, 8'h55, 0, -1, -1);
    idle_check(0, 3);

    // Back-to-back 0xA3, 0x0F: second pop exactly F+1 cycles after the first
    @(posedge clk); #1;
    push(0, 8'hA3);
    push(0, 8'h0F);
    run_frame(0, 8'hA3, 0, -1, -1);
    run_frame(0, 8'h0F, 0, -1, -1);
    idle_check(0, 20);
    check("fifo_a_empty", rd_a, wr_a);

    // Even parity and two stop bits on B
    @(posedge clk); #1;
    push(1, 8'h07);
    run_frame(1, 8'h07, 0, -1, -1);
    idle_check(1, 5);

    // Reset during data bit 3 of 0xFF
    @(posedge clk); #1;
    push(0, 8'hFF);
    run_frame(0, 8'hFF, 0, -1, 18);
    idle_check(0, 30);

    // Enable gating: drop i_tx_en in the start bit with two words queued
    @(posedge clk); #1;
    push(0, 8'h3C);
    push(0, 8'hC3);
    run_frame(0, 8'h3C, 0, 2, -1);
    idle_check(0, 60);
    @(posedge clk); #1;
    tx_en_a = 1'b1;
    run_frame(0, 8'hC3, 0, -1, -1);
    idle_check(0, 5);

    // Randomized back-to-back words on both instances
    for (int i = 0; i < 4; i++) rw[i] = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(0, rw[i]);
    for (int i = 0; i < 4; i++) run_frame(0, rw[i], 0, -1, -1);
    idle_check(0, 5);
    for (int i = 0; i < 3; i++) rw[i] = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(1, rw[i]);
    for (int i = 0; i < 3; i++) run_frame(1, rw[i], 0, -1, -1);
    idle_check(1, 5);
    check("fifo_b_empty", rd_b, wr_b);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
